// File: rtl/alu_pkg.sv
// Shared definitions for the ALU: opcode encoding and operation type.
// Optional flag outputs are enabled by defining ALU_FLAGS_EN.
package alu_pkg;

    typedef logic [1:0] alu_op_t;

    localparam alu_op_t OP_AND = 2'b00;
    localparam alu_op_t OP_OR  = 2'b01;
    localparam alu_op_t OP_ADD = 2'b10;
    localparam alu_op_t OP_SUB = 2'b11;

endpackage : alu_pkg

// File: rtl/alu_core.sv
// Combinational ALU datapath: operand zeroing, AND/OR/ADD/SUB, and bitwise
// output inversion. When ALU_FLAGS_EN is defined it also produces the
// zr/ng/carry/overflow flags for the post-negation result.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             zero_x,
    input  logic             zero_y,
    input  logic             negate_output,
    input  logic [1:0]       opcode,
`ifdef ALU_FLAGS_EN
    output logic             zr,
    output logic             ng,
    output logic             carry,
    output logic             overflow,
`endif
    output logic [WIDTH-1:0] result
);

    logic [WIDTH-1:0] xa;
    logic [WIDTH-1:0] ya;
    logic [WIDTH-1:0] op_result;

    // Operand stage: optionally force either operand to zero.
    always_comb begin
        xa = zero_x ? '0 : x;
        ya = zero_y ? '0 : y;
    end

`ifdef ALU_FLAGS_EN
    // Carry/borrow needs one extra bit, so ADD/SUB are computed wide here.
    logic [WIDTH:0] sum_w;
    logic [WIDTH:0] diff_w;

    // Operation select with carry-out, borrow-free and signed overflow.
    always_comb begin
        sum_w     = {1'b0, xa} + {1'b0, ya};
        diff_w    = {1'b0, xa} - {1'b0, ya};
        op_result = '0;
        carry     = 1'b0;
        overflow  = 1'b0;
        case (alu_op_t'(opcode))
            OP_AND: op_result = xa & ya;
            OP_OR:  op_result = xa | ya;
            OP_ADD: begin
                op_result = sum_w[WIDTH-1:0];
                carry     = sum_w[WIDTH];
                overflow  = (xa[WIDTH-1] == ya[WIDTH-1]) &&
                            (sum_w[WIDTH-1] != xa[WIDTH-1]);
            end
            default: begin
                op_result = diff_w[WIDTH-1:0];
                // A clear borrow bit means xa >= ya (unsigned).
                carry     = ~diff_w[WIDTH];
                overflow  = (xa[WIDTH-1] != ya[WIDTH-1]) &&
                            (diff_w[WIDTH-1] != xa[WIDTH-1]);
            end
        endcase
    end
`else
    // Operation select; ADD/SUB wrap modulo 2^WIDTH.
    always_comb begin
        op_result = '0;
        case (alu_op_t'(opcode))
            OP_AND:  op_result = xa & ya;
            OP_OR:   op_result = xa | ya;
            OP_ADD:  op_result = xa + ya;
            default: op_result = xa - ya;
        endcase
    end
`endif

    // Post stage: bitwise NOT (not arithmetic negate) when requested.
    always_comb begin
        result = negate_output ? ~op_result : op_result;
    end

`ifdef ALU_FLAGS_EN
    // Result-derived flags describe the value actually registered.
    always_comb begin
        zr = (result == '0);
        ng = result[WIDTH-1];
    end
`endif

endmodule : alu_core

// File: rtl/alu.sv
// Registered ALU top: one-cycle latency from inputs to output_result.
// Synchronous active-low reset clears the result (and the flags when
// ALU_FLAGS_EN is defined) with priority over the computed value.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             zero_x,
    input  logic             zero_y,
    input  logic             negate_output,
    input  logic [1:0]       opcode,
`ifdef ALU_FLAGS_EN
    output logic             zr,
    output logic             ng,
    output logic             carry,
    output logic             overflow,
`endif
    output logic [WIDTH-1:0] output_result
);

    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] output_result_d;
    logic [WIDTH-1:0] output_result_q;

`ifdef ALU_FLAGS_EN
    logic [3:0] flags_c;
    logic [3:0] flags_d;
    logic [3:0] flags_q;
`endif

    alu_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .x            (x),
        .y            (y),
        .zero_x       (zero_x),
        .zero_y       (zero_y),
        .negate_output(negate_output),
        .opcode       (opcode),
`ifdef ALU_FLAGS_EN
        .zr           (flags_c[3]),
        .ng           (flags_c[2]),
        .carry        (flags_c[1]),
        .overflow     (flags_c[0]),
`endif
        .result       (r)
    );

    // Next-state: reset wins over the computed result.
    always_comb begin
        output_result_d = rst_n ? r : '0;
`ifdef ALU_FLAGS_EN
        flags_d = rst_n ? flags_c : 4'b0000;
`endif
    end

    // Output registers, updated every cycle (no enable).
    always_ff @(posedge clk) begin
        output_result_q <= output_result_d;
`ifdef ALU_FLAGS_EN
        flags_q <= flags_d;
`endif
    end

    assign output_result = output_result_q;
`ifdef ALU_FLAGS_EN
    assign zr       = flags_q[3];
    assign ng       = flags_q[2];
    assign carry    = flags_q[1];
    assign overflow = flags_q[0];
`endif

endmodule : alu

// File: tb/tb_alu.sv
// Directed bench for alu: hand-computed vectors checked with immediate
// assertions one cycle after each input change. Flag checks are compiled
// in when ALU_FLAGS_EN is defined.
module tb_alu;

    localparam int W = 16;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         zero_x;
    logic         zero_y;
    logic         negate_output;
    logic [1:0]   opcode;
    logic [W-1:0] output_result;
`ifdef ALU_FLAGS_EN
    logic         zr;
    logic         ng;
    logic         carry;
    logic         overflow;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    alu #(
        .WIDTH(W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .x            (x),
        .y            (y),
        .zero_x       (zero_x),
        .zero_y       (zero_y),
        .negate_output(negate_output),
        .opcode       (opcode),
`ifdef ALU_FLAGS_EN
        .zr           (zr),
        .ng           (ng),
        .carry        (carry),
        .overflow     (overflow),
`endif
        .output_result(output_result)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input logic [W-1:0] xv, input logic [W-1:0] yv,
                           input logic [1:0] op, input logic zx, input logic zy,
                           input logic neg);
        x = xv; y = yv; opcode = op; zero_x = zx; zero_y = zy; negate_output = neg;
    endtask

`ifdef ALU_FLAGS_EN
    task automatic check_flags(input string tag, input logic ezr, input logic eng,
                               input logic ec, input logic eov);
        check({tag, "_zr"}, {15'd0, zr}, {15'd0, ezr});
        check({tag, "_ng"}, {15'd0, ng}, {15'd0, eng});
        check({tag, "_carry"}, {15'd0, carry}, {15'd0, ec});
        check({tag, "_ovf"}, {15'd0, overflow}, {15'd0, eov});
    endtask
`endif

    initial begin
        // Reset with pending ADD 0x1234 + 0x1111
        rst_n = 1'b0;
        set_ops(16'h1234, 16'h1111, 2'b10, 1'b0, 1'b0, 1'b0);
        tick();
        check("reset_cyc1", output_result, 16'h0000);
        tick();
        check("reset_cyc2", output_result, 16'h0000);
`ifdef ALU_FLAGS_EN
        check_flags("reset", 1'b0, 1'b0, 1'b0, 1'b0);
`endif
        rst_n = 1'b1;
        tick();
        check("reset_release", output_result, 16'h2345);

        // ADD sequence
        set_ops(16'd2, 16'd5, 2'b10, 1'b0, 1'b0, 1'b0);
        #1;
        check("latency_hold", output_result, 16'h2345);
        tick();
        check("add_2_5", output_result, 16'd7);
        x = 16'h0010;
        tick();
        check("add_10_5", output_result, 16'h0015);
        zero_x = 1'b1;
        tick();
        check("add_zx", output_result, 16'd5);

        // Logic ops
        set_ops(16'h00FF, 16'h0F0F, 2'b00, 1'b0, 1'b0, 1'b0);
        tick();
        check("and", output_result, 16'h000F);
        opcode = 2'b01;
        tick();
        check("or", output_result, 16'h0FFF);
        set_ops(16'h00FF, 16'h0F0F, 2'b00, 1'b0, 1'b0, 1'b1);
        tick();
        check("nand", output_result, 16'hFFF0);
        opcode = 2'b01;
        tick();
        check("nor", output_result, 16'hF000);

        // SUB and wrap
        set_ops(16'h0000, 16'h0001, 2'b11, 1'b0, 1'b0, 1'b0);
        tick();
        check("sub_wrap", output_result, 16'hFFFF);
`ifdef ALU_FLAGS_EN
        check_flags("sub_wrap", 1'b0, 1'b1, 1'b0, 1'b0);
`endif
        set_ops(16'hFFFF, 16'h0001, 2'b10, 1'b0, 1'b0, 1'b0);
        tick();
        check("add_wrap", output_result, 16'h0000);
`ifdef ALU_FLAGS_EN
        check_flags("add_wrap", 1'b1, 1'b0, 1'b1, 1'b0);
`endif
        set_ops(16'h0005, 16'h0003, 2'b11, 1'b0, 1'b0, 1'b0);
        tick();
        check("sub_5_3", output_result, 16'h0002);
`ifdef ALU_FLAGS_EN
        check_flags("sub_5_3", 1'b0, 1'b0, 1'b1, 1'b0);
`endif

        // Both operands zeroed, inverted output, every opcode
        set_ops(16'hABCD, 16'h1357, 2'b00, 1'b1, 1'b1, 1'b1);
        tick();
        check("zz_and", output_result, 16'hFFFF);
        opcode = 2'b01;
        tick();
        check("zz_or", output_result, 16'hFFFF);
        opcode = 2'b10;
        tick();
        check("zz_add", output_result, 16'hFFFF);
`ifdef ALU_FLAGS_EN
        check_flags("zz_add", 1'b0, 1'b1, 1'b0, 1'b0);
`endif
        opcode = 2'b11;
        tick();
        check("zz_sub", output_result, 16'hFFFF);
        negate_output = 1'b0;
        tick();
        check("zz_sub_noneg", output_result, 16'h0000);

        // Signed overflow, then mid-stream reset
        set_ops(16'h7FFF, 16'h0001, 2'b10, 1'b0, 1'b0, 1'b0);
        tick();
        check("add_ovf", output_result, 16'h8000);
`ifdef ALU_FLAGS_EN
        check_flags("add_ovf", 1'b0, 1'b1, 1'b0, 1'b1);
`endif
        rst_n = 1'b0;
        tick();
        check("mid_reset", output_result, 16'h0000);
`ifdef ALU_FLAGS_EN
        check_flags("mid_reset", 1'b0, 1'b0, 1'b0, 1'b0);
`endif
        rst_n = 1'b1;
        tick();
        check("post_reset", output_result, 16'h8000);

        set_ops(16'h8000, 16'h0001, 2'b11, 1'b0, 1'b0, 1'b0);
        tick();
        check("sub_ovf", output_result, 16'h7FFF);
`ifdef ALU_FLAGS_EN
        check_flags("sub_ovf", 1'b0, 1'b0, 1'b1, 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_alu
